rename_stage: RTL
=================

# rename_stage

Two-wide register-rename stage between instruction decode and the reservation station. Each cycle it maps architectural `rs1`/`rs2`/`rd` of up to two decoded instructions to 6-bit physical registers. It allocates new destinations from a circular free list and reports each previous mapping (`p_old_rd`). Physical registers freed by ROB retire are returned to the free list. Outputs are registered and feed the reservation station's `instr1_*`/`instr2_*` inputs directly.

## Interface
- `PHYS_REGS`, 64: physical register count (6-bit tags); p0 is the hard-wired zero register.
- `ARCH_REGS`, 32: architectural register count.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instrN_opcode`  in  7  N=1,2; decoded opcode; 0 = empty slot.
- `instrN_rs1`, `instrN_rs2`, `instrN_rd`  in  5  architectural register fields.
- `instrN_imm` / `instrN_funct7` / `instrN_funct3`  in  32/7/3  passed through.
- `free_reg1`, `free_reg2`  in  6  tags freed by retire; 0 = none.
- `stall`  out  1  combinational; group not accepted this cycle, decode must hold.
- `instrN_opcode_out`, `instrN_imm_out`, `instrN_funct7_out`, `instrN_funct3_out`  out  7/32/7/3  registered pass-through.
- `instrN_p_rs1`, `instrN_p_rs2`, `instrN_p_rd`, `instrN_p_old_rd`  out  6  registered physical tags.

## Operation
- Writer opcodes are 0110011 (R), 0010011 (I) and 0000011 (lw). An instruction needs allocation only if its slot is non-empty, its opcode is a writer, and `rd != 0`.
- sw and other non-writers get `p_rd = 0` and `p_old_rd = 0`. Their source tags are still renamed.
- RAT: 32 × 6-bit entries. x0 always maps to p0 and is never written.
- Free list: circular FIFO of depth `PHYS_REGS`, with 6-bit `head`/`tail` and a 7-bit `count`.
- `need` = number of allocating instructions in the group (0–2).
- `stall = (need > count)`. This is all-or-nothing: a stalled group allocates nothing, and both output slots become bubbles (opcode 0, all tags 0).
- When the group is accepted:
  - instr1 pops `head`.
  - instr2 pops the next entry: `head+1` if instr1 allocated, otherwise `head`.
  - `head` advances by `need`.
- Intra-group bypass:
  - If instr1 allocates and `instr2_rsK == instr1_rd`, then `instr2_p_rsK` = instr1's new tag.
  - If both allocate with the same `rd`, then `instr2_p_old_rd` = instr1's new tag.
  - The RAT ends with instr2's tag for that `rd`.
- Sources and `p_old_rd` otherwise read the RAT state from before this cycle's updates.
- Freeing:
  - Each nonzero `free_regK` is pushed at `tail`; free_reg1 goes first if both are valid.
  - `tail` advances by the number of valid frees.
  - Freed tags are usable from the next cycle only; `stall` uses the current `count`.
- `count_next = count − popped + pushed`. Pops and pushes in the same cycle are legal.
- The free list cannot overflow: at most 63 tags exist outside p0. Overflow is not checked.
- `free_reg` arriving during a stall is still pushed.

## Timing
- Latency: 1 cycle from decode inputs to registered outputs.
- On a stall cycle, the outputs register bubbles on the next edge.
- Reset values:
  - RAT[i] = p_i for i = 0..31.
  - Free list entries 0..31 hold p32..p63; `head` = 0, `tail` = 32, `count` = 32.
  - All registered outputs are 0; `stall` is 0 once `reset` is asserted (reset overrides).
- Reset mid-operation discards all in-flight mappings. Inputs are ignored while `reset` is high.
- `head`/`tail` wrap modulo 64.

## Test plan
- **Reset:** assert `reset` 1 cycle, then single `add x5,x1,x2`. Next cycle: `p_rs1` = 1, `p_rs2` = 2, `p_rd` = 32, `p_old_rd` = 5.
- **Intra-group bypass:** pair `add x5,x1,x2` ; `sub x6,x5,x5`.
  - instr1: `p_rd` = 32.
  - instr2: `p_rs1` = `p_rs2` = 32, `p_rd` = 33, `p_old_rd` = 6.
- **Same-rd pair:** `addi x7` ; `addi x7`. Tags 32/33; instr2 `p_old_rd` = 32. A later read of x7 gives 33.
- **No-alloc slots:** `sw x3,0(x4)` plus `addi x0,x1,1`. Both give `p_rd` = 0 and `p_old_rd` = 0; `count` stays 32.
- **Exhaustion and free:**
  - Issue 16 writer pairs → `count` = 0. The next writer pair raises `stall` and the outputs are bubbles.
  - Drive `free_reg1` = 5, `free_reg2` = 6 on that stall cycle → `stall` drops the following cycle and the pair receives 5 and 6.
- **Wrap-around / reset mid-stream:**
  - Cycle 64+ allocations with matched frees; verify the tags recycled in FIFO order across wrap.
  - Assert `reset` mid-stream; the next `add x5` again gets `p_rd` = 32.

Source files
------------

// File: rtl/rename_stage.sv
// Two-wide register rename stage: RAT lookup, circular free-list allocation,
// intra-group bypass and retire-driven freeing, with registered outputs.
module rename_stage #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  instr1_opcode,
    input  logic [4:0]  instr1_rs1,
    input  logic [4:0]  instr1_rs2,
    input  logic [4:0]  instr1_rd,
    input  logic [31:0] instr1_imm,
    input  logic [6:0]  instr1_funct7,
    input  logic [2:0]  instr1_funct3,
    input  logic [6:0]  instr2_opcode,
    input  logic [4:0]  instr2_rs1,
    input  logic [4:0]  instr2_rs2,
    input  logic [4:0]  instr2_rd,
    input  logic [31:0] instr2_imm,
    input  logic [6:0]  instr2_funct7,
    input  logic [2:0]  instr2_funct3,
    input  logic [5:0]  free_reg1,
    input  logic [5:0]  free_reg2,
    output logic        stall,
    output logic [6:0]  instr1_opcode_out,
    output logic [31:0] instr1_imm_out,
    output logic [6:0]  instr1_funct7_out,
    output logic [2:0]  instr1_funct3_out,
    output logic [5:0]  instr1_p_rs1,
    output logic [5:0]  instr1_p_rs2,
    output logic [5:0]  instr1_p_rd,
    output logic [5:0]  instr1_p_old_rd,
    output logic [6:0]  instr2_opcode_out,
    output logic [31:0] instr2_imm_out,
    output logic [6:0]  instr2_funct7_out,
    output logic [2:0]  instr2_funct3_out,
    output logic [5:0]  instr2_p_rs1,
    output logic [5:0]  instr2_p_rs2,
    output logic [5:0]  instr2_p_rd,
    output logic [5:0]  instr2_p_old_rd
);

    // Handshake: the group is accepted on a rising edge when stall is low;
    // while stall is high decode must hold its group and nothing is allocated.
    function automatic logic is_writer(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011);
    endfunction

    logic [5:0] rat [ARCH_REGS];
    logic [5:0] fl  [PHYS_REGS];
    logic [5:0] head, tail;
    logic [6:0] count;

    logic       alloc1, alloc2, f1v, f2v;
    logic [1:0] need, nfree, popped;
    logic [5:0] new1, new2, tail2;
    logic [5:0] p1_rs1, p1_rs2, p1_rd, p1_old;
    logic [5:0] p2_rs1, p2_rs2, p2_rd, p2_old;

    always_comb begin
        alloc1 = is_writer(instr1_opcode) && (instr1_rd != 5'd0);
        alloc2 = is_writer(instr2_opcode) && (instr2_rd != 5'd0);
        need   = {1'b0, alloc1} + {1'b0, alloc2};
        stall  = !reset && ({5'd0, need} > count);
        popped = stall ? 2'd0 : need;
        f1v    = (free_reg1 != 6'd0);
        f2v    = (free_reg2 != 6'd0);
        nfree  = {1'b0, f1v} + {1'b0, f2v};
        tail2  = f1v ? tail + 6'd1 : tail;

        new1   = fl[head];
        new2   = alloc1 ? fl[head + 6'd1] : fl[head];

        p1_rs1 = rat[instr1_rs1];
        p1_rs2 = rat[instr1_rs2];
        p1_rd  = alloc1 ? new1 : 6'd0;
        p1_old = alloc1 ? rat[instr1_rd] : 6'd0;

        // instr2 sees instr1's fresh mapping as if the pair issued in order
        p2_rs1 = (alloc1 && instr2_rs1 == instr1_rd) ? new1 : rat[instr2_rs1];
        p2_rs2 = (alloc1 && instr2_rs2 == instr1_rd) ? new1 : rat[instr2_rs2];
        p2_rd  = alloc2 ? new2 : 6'd0;
        p2_old = 6'd0;
        if (alloc2) begin
            p2_old = (alloc1 && instr2_rd == instr1_rd) ? new1 : rat[instr2_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= 6'(i);
            for (int i = 0; i < PHYS_REGS; i++) fl[i] <= (i < 32) ? 6'(i + 32) : 6'd0;
            head  <= 6'd0;
            tail  <= 6'd32;
            count <= 7'd32;
            instr1_opcode_out <= '0; instr1_imm_out <= '0;
            instr1_funct7_out <= '0; instr1_funct3_out <= '0;
            instr1_p_rs1 <= '0; instr1_p_rs2 <= '0; instr1_p_rd <= '0; instr1_p_old_rd <= '0;
            instr2_opcode_out <= '0; instr2_imm_out <= '0;
            instr2_funct7_out <= '0; instr2_funct3_out <= '0;
            instr2_p_rs1 <= '0; instr2_p_rs2 <= '0; instr2_p_rd <= '0; instr2_p_old_rd <= '0;
        end else begin
            // Frees are pushed even on a stall cycle
            if (f1v) fl[tail]  <= free_reg1;
            if (f2v) fl[tail2] <= free_reg2;
            tail  <= tail + {4'd0, nfree};
            count <= count - {5'd0, popped} + {5'd0, nfree};
            if (stall) begin
                instr1_opcode_out <= '0; instr1_imm_out <= '0;
                instr1_funct7_out <= '0; instr1_funct3_out <= '0;
                instr1_p_rs1 <= '0; instr1_p_rs2 <= '0; instr1_p_rd <= '0; instr1_p_old_rd <= '0;
                instr2_opcode_out <= '0; instr2_imm_out <= '0;
                instr2_funct7_out <= '0; instr2_funct3_out <= '0;
                instr2_p_rs1 <= '0; instr2_p_rs2 <= '0; instr2_p_rd <= '0; instr2_p_old_rd <= '0;
            end else begin
                if (alloc1) rat[instr1_rd] <= new1;
                if (alloc2) rat[instr2_rd] <= new2;
                head <= head + {4'd0, need};
                instr1_opcode_out <= instr1_opcode; instr1_imm_out <= instr1_imm;
                instr1_funct7_out <= instr1_funct7; instr1_funct3_out <= instr1_funct3;
                instr1_p_rs1 <= p1_rs1; instr1_p_rs2 <= p1_rs2;
                instr1_p_rd  <= p1_rd;  instr1_p_old_rd <= p1_old;
                instr2_opcode_out <= instr2_opcode; instr2_imm_out <= instr2_imm;
                instr2_funct7_out <= instr2_funct7; instr2_funct3_out <= instr2_funct3;
                instr2_p_rs1 <= p2_rs1; instr2_p_rs2 <= p2_rs2;
                instr2_p_rd  <= p2_rd;  instr2_p_old_rd <= p2_old;
            end
        end
    end

endmodule
